// File: rtl/hygro_i2c_target_if.sv
`timescale 1ns/1ps
// I2C pin bundle for the hygrometer target: raw SCL/SDA levels in, open-drain SDA pull-down out.
interface hygro_i2c_target_if;
  logic scl_in;
  logic sda_in;
  logic sda_oe;

  modport slave  (input scl_in, input sda_in, output sda_oe);
  modport master (output scl_in, output sda_in, input sda_oe);
endinterface

// File: rtl/hygro_i2c_target.sv
`timescale 1ns/1ps
// I2C target for a temperature/humidity sensor: an address write triggers a timed conversion,
// an address read returns the snapshot taken when that conversion finished.
module hygro_i2c_target #(
  parameter logic [6:0]  ADDR        = 7'h40,
  parameter logic [15:0] CONV_CYCLES = 16'd1000
) (
  input  logic               clk,
  input  logic               rst,
  hygro_i2c_target_if.slave  bus,
  input  logic [13:0]        tem_in,
  input  logic [13:0]        hum_in,
  output logic               meas_req,
  output logic               conv_busy,
  output logic               xfer_active
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR, S_WR_ACK, S_RD, S_RD_ACK, S_IGNORE
  } state_t;

  logic       r_scl_meta, r_scl_sync, r_scl_prev;
  logic       r_sda_meta, r_sda_sync, r_sda_prev;
  logic [2:0] r_warm;

  state_t      r_state, w_state_next;
  logic [3:0]  r_bit_cnt, w_bit_cnt_next;
  logic [2:0]  r_byte_idx, w_byte_idx_next;
  logic [6:0]  r_shift, w_shift_next;
  logic        r_rw, w_rw_next;
  logic        r_ack_on, w_ack_on_next;
  logic        r_sda_oe, w_sda_oe_next;
  logic        r_xfer, w_xfer_next;
  logic        r_meas_req, w_meas_trig;

  logic        r_conv_busy;
  logic [15:0] r_conv_cnt;
  logic [13:0] r_snap_tem, r_snap_hum;

  logic        w_det_en, w_scl_rise, w_scl_fall, w_start, w_stop;
  logic [7:0]  w_addr_byte, w_rd_byte;
  logic [2:0]  w_bit_idx;

  // Sync chain resets to the idle-bus level; detection waits until the chain holds real samples
  // so a reset release mid-transfer cannot fabricate a START.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scl_meta <= 1'b1;
      r_scl_sync <= 1'b1;
      r_scl_prev <= 1'b1;
      r_sda_meta <= 1'b1;
      r_sda_sync <= 1'b1;
      r_sda_prev <= 1'b1;
      r_warm     <= 3'b000;
    end else begin
      r_scl_meta <= bus.scl_in;
      r_scl_sync <= r_scl_meta;
      r_scl_prev <= r_scl_sync;
      r_sda_meta <= bus.sda_in;
      r_sda_sync <= r_sda_meta;
      r_sda_prev <= r_sda_sync;
      r_warm     <= {r_warm[1:0], 1'b1};
    end
  end

  assign w_det_en   = r_warm[2];
  assign w_scl_rise = w_det_en &  r_scl_sync & ~r_scl_prev;
  assign w_scl_fall = w_det_en & ~r_scl_sync &  r_scl_prev;
  assign w_start    = w_det_en & r_scl_sync & r_scl_prev &  r_sda_prev & ~r_sda_sync;
  assign w_stop     = w_det_en & r_scl_sync & r_scl_prev & ~r_sda_prev &  r_sda_sync;

  assign w_addr_byte = {r_shift, r_sda_sync};
  assign w_bit_idx   = 3'd7 - r_bit_cnt[2:0];

  always_comb begin
    case (r_byte_idx)
      3'd0:    w_rd_byte = r_snap_tem[13:6];
      3'd1:    w_rd_byte = {r_snap_tem[5:0], 2'b00};
      3'd2:    w_rd_byte = r_snap_hum[13:6];
      3'd3:    w_rd_byte = {r_snap_hum[5:0], 2'b00};
      default: w_rd_byte = 8'hFF;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= 4'd0;
      r_byte_idx <= 3'd0;
      r_shift    <= 7'd0;
      r_rw       <= 1'b0;
      r_ack_on   <= 1'b0;
      r_sda_oe   <= 1'b0;
      r_xfer     <= 1'b0;
      r_meas_req <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_byte_idx <= w_byte_idx_next;
      r_shift    <= w_shift_next;
      r_rw       <= w_rw_next;
      r_ack_on   <= w_ack_on_next;
      r_sda_oe   <= w_sda_oe_next;
      r_xfer     <= w_xfer_next;
      r_meas_req <= w_meas_trig;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_bit_cnt_next  = r_bit_cnt;
    w_byte_idx_next = r_byte_idx;
    w_shift_next    = r_shift;
    w_rw_next       = r_rw;
    w_ack_on_next   = r_ack_on;
    w_sda_oe_next   = r_sda_oe;
    w_xfer_next     = r_xfer;
    w_meas_trig     = 1'b0;
    if (w_stop) begin
      w_state_next  = S_IDLE;
      w_sda_oe_next = 1'b0;
      w_xfer_next   = 1'b0;
      w_ack_on_next = 1'b0;
    end else if (w_start) begin
      w_state_next    = S_ADDR;
      w_bit_cnt_next  = 4'd0;
      w_byte_idx_next = 3'd0;
      w_sda_oe_next   = 1'b0;
      w_xfer_next     = 1'b0;
      w_ack_on_next   = 1'b0;
    end else begin
      case (r_state)
        S_ADDR: begin
          if (w_scl_rise) begin
            w_shift_next   = w_addr_byte[6:0];
            w_rw_next      = r_sda_sync;
            w_bit_cnt_next = r_bit_cnt + 4'd1;
            if (r_bit_cnt == 4'd7) begin
              w_bit_cnt_next = 4'd0;
              // Reads are refused while a conversion is running so stale data is never returned.
              if (w_addr_byte[7:1] == ADDR && (!r_sda_sync || !r_conv_busy)) begin
                w_state_next  = S_ADDR_ACK;
                w_xfer_next   = 1'b1;
                w_ack_on_next = 1'b0;
              end else begin
                w_state_next = S_IGNORE;
              end
            end
          end
        end
        S_ADDR_ACK, S_WR_ACK: begin
          if (w_scl_fall) begin
            if (!r_ack_on) begin
              w_sda_oe_next = 1'b1;
              w_ack_on_next = 1'b1;
            end else begin
              w_ack_on_next  = 1'b0;
              w_sda_oe_next  = 1'b0;
              w_bit_cnt_next = 4'd0;
              if (r_state == S_WR_ACK || !r_rw) begin
                w_state_next = S_WR;
                if (r_state == S_ADDR_ACK) w_meas_trig = ~r_conv_busy;
              end else begin
                w_state_next   = S_RD;
                w_sda_oe_next  = ~w_rd_byte[7];
                w_bit_cnt_next = 4'd1;
              end
            end
          end
        end
        S_WR: begin
          if (w_scl_rise) begin
            w_bit_cnt_next = r_bit_cnt + 4'd1;
            if (r_bit_cnt == 4'd7) begin
              w_state_next   = S_WR_ACK;
              w_bit_cnt_next = 4'd0;
              w_ack_on_next  = 1'b0;
            end
          end
        end
        S_RD: begin
          if (w_scl_fall) begin
            if (r_bit_cnt[3]) begin
              w_sda_oe_next = 1'b0;
              w_state_next  = S_RD_ACK;
            end else begin
              w_sda_oe_next  = ~w_rd_byte[w_bit_idx];
              w_bit_cnt_next = r_bit_cnt + 4'd1;
            end
          end
        end
        S_RD_ACK: begin
          if (w_scl_rise) begin
            if (!r_sda_sync) begin
              w_state_next    = S_RD;
              w_bit_cnt_next  = 4'd0;
              w_byte_idx_next = (r_byte_idx == 3'd4) ? 3'd4 : r_byte_idx + 3'd1;
            end else begin
              w_state_next = S_IGNORE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Conversion timer: busy for exactly CONV_CYCLES clocks, snapshot taken on the final one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_conv_busy <= 1'b0;
      r_conv_cnt  <= 16'd0;
      r_snap_tem  <= 14'd0;
      r_snap_hum  <= 14'd0;
    end else if (w_meas_trig) begin
      r_conv_busy <= 1'b1;
      r_conv_cnt  <= CONV_CYCLES;
    end else if (r_conv_busy) begin
      if (r_conv_cnt <= 16'd1) begin
        r_conv_cnt  <= 16'd0;
        r_conv_busy <= 1'b0;
        r_snap_tem  <= tem_in;
        r_snap_hum  <= hum_in;
      end else begin
        r_conv_cnt <= r_conv_cnt - 16'd1;
      end
    end
  end

  assign bus.sda_oe  = r_sda_oe;
  assign meas_req    = r_meas_req;
  assign conv_busy   = r_conv_busy;
  assign xfer_active = r_xfer;

endmodule

// File: tb/tb_hygro_i2c_target.sv
`timescale 1ns/1ps
// Bench for hygro_i2c_target: bit-banged I2C master, fixed read vectors, hand sequences, random reads.
module tb_hygro_i2c_target;
  localparam int QTR  = 6;
  localparam int CONV = 600;

  typedef struct {
    logic [13:0]     tem;
    logic [13:0]     hum;
    logic [0:4][7:0] exp;
    int              nrd;
  } rd_vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m_scl = 1'b1;
  logic        m_sda = 1'b1;
  logic [13:0] tem_in = 14'd0;
  logic [13:0] hum_in = 14'd0;
  logic        meas_req, conv_busy, xfer_active;

  hygro_i2c_target_if bus();
  assign bus.scl_in = m_scl;
  assign bus.sda_in = m_sda & ~bus.sda_oe;

  hygro_i2c_target #(.ADDR(7'h40), .CONV_CYCLES(16'(CONV))) dut (
    .clk(clk), .rst(rst), .bus(bus), .tem_in(tem_in), .hum_in(hum_in),
    .meas_req(meas_req), .conv_busy(conv_busy), .xfer_active(xfer_active)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_tot = 0;
  int meas_cnt = 0, busy_cyc = 0, oe_seen = 0;
  bit mon_en = 1'b0;

  always @(negedge clk) begin
    if (meas_req) meas_cnt++;
    if (conv_busy) busy_cyc++;
    if (mon_en && bus.sda_oe) oe_seen++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  function automatic logic [7:0] model_byte(input int idx, input logic [13:0] t, input logic [13:0] h);
    int v;
    case (idx)
      0:       v = int'(t) / 64;
      1:       v = (int'(t) % 64) * 4;
      2:       v = int'(h) / 64;
      3:       v = (int'(h) % 64) * 4;
      default: v = 255;
    endcase
    return 8'(v);
  endfunction

  task automatic q();
    repeat (QTR) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; q(); m_scl = 1'b1; q(); m_sda = 1'b0; q(); m_scl = 1'b0; q();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; q(); m_scl = 1'b1; q(); m_sda = 1'b1; q();
  endtask

  task automatic clk_bit(input logic b, output logic s);
    m_sda = b; q(); m_scl = 1'b1; q(); s = bus.sda_in; q(); m_scl = 1'b0; q();
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(d[i], s);
    clk_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic rd_byte(input logic mack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      d[i] = s;
    end
    clk_bit(~mack, s);
  endtask

  task automatic wait_conv();
    int n = 0;
    while (conv_busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("conv_done", int'(conv_busy), 0);
  endtask

  task automatic trigger();
    logic ack;
    i2c_start();
    wr_byte(8'h80, ack);
    chk("trig_ack", int'(ack), 1);
    i2c_stop();
    $display("txn: write 0x80 trigger ack=%0d", ack);
  endtask

  rd_vec_t vecs [3];

  initial begin
    logic        ack, s;
    logic [7:0]  d;
    logic [6:0]  a7;
    logic [13:0] t, h;
    int          n;
    bit          exp_ack;

    vecs[0] = '{14'h2ABC, 14'h1234, {8'hAA, 8'hF0, 8'h48, 8'hD0, 8'hFF}, 4};
    vecs[1] = '{14'h3FFF, 14'h0000, {8'hFF, 8'hFC, 8'h00, 8'h00, 8'hFF}, 5};
    vecs[2] = '{14'h0001, 14'h2000, {8'h00, 8'h04, 8'h80, 8'h00, 8'hFF}, 5};

    repeat (3) @(negedge clk);
    chk("rst_sda_oe", int'(bus.sda_oe), 0);
    chk("rst_meas_req", int'(meas_req), 0);
    chk("rst_conv_busy", int'(conv_busy), 0);
    chk("rst_xfer_active", int'(xfer_active), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Write trigger: ACK, single meas_req, busy for CONV clocks
    meas_cnt = 0; busy_cyc = 0;
    i2c_start();
    wr_byte(8'h80, ack);
    chk("w80_ack", int'(ack), 1);
    chk("w80_xfer", int'(xfer_active), 1);
    i2c_stop();
    chk("w80_xfer_after_stop", int'(xfer_active), 0);
    $display("txn: write 0x80 ack=%0d", ack);
    wait_conv();
    chk("w80_meas_pulses", meas_cnt, 1);
    chk("w80_busy_cycles", busy_cyc, CONV);

    // Write while busy is ACKed without retrigger; read while busy is NACKed
    meas_cnt = 0;
    trigger();
    i2c_start();
    wr_byte(8'h80, ack);
    chk("busy_write_ack", int'(ack), 1);
    i2c_stop();
    chk("busy_write_no_retrigger", meas_cnt, 1);
    i2c_start();
    wr_byte(8'h81, ack);
    chk("busy_read_nack", int'(ack), 0);
    chk("busy_still_converting", int'(conv_busy), 1);
    mon_en = 1'b1; oe_seen = 0;
    rd_byte(1'b0, d);
    i2c_stop();
    mon_en = 1'b0;
    chk("busy_read_no_drive", oe_seen, 0);
    $display("txn: read 0x81 while busy ack=%0d", ack);
    wait_conv();

    // Wrong address
    mon_en = 1'b1; oe_seen = 0;
    i2c_start();
    wr_byte(8'h92, ack);
    chk("w92_nack", int'(ack), 0);
    chk("w92_xfer", int'(xfer_active), 0);
    rd_byte(1'b0, d);
    i2c_stop();
    mon_en = 1'b0;
    chk("w92_no_drive", oe_seen, 0);
    $display("txn: write 0x92 ack=%0d", ack);

    // Table-driven reads
    for (int v = 0; v < 3; v++) begin
      tem_in = vecs[v].tem; hum_in = vecs[v].hum;
      trigger();
      wait_conv();
      tem_in = ~vecs[v].tem; hum_in = ~vecs[v].hum;
      i2c_start();
      wr_byte(8'h81, ack);
      chk("vec_addr_ack", int'(ack), 1);
      chk("vec_xfer", int'(xfer_active), 1);
      for (int i = 0; i < vecs[v].nrd; i++) begin
        rd_byte(i != vecs[v].nrd - 1, d);
        chk($sformatf("vec%0d_byte%0d", v, i), int'(d), int'(vecs[v].exp[i]));
      end
      chk("vec_released_after_nack", int'(bus.sda_oe), 0);
      i2c_stop();
      $display("txn: vector %0d read %0d bytes", v, vecs[v].nrd);
    end

    // Five ACKed bytes, then repeated START restarts at byte 0
    tem_in = 14'h2ABC; hum_in = 14'h1234;
    trigger();
    wait_conv();
    i2c_start();
    wr_byte(8'h81, ack);
    chk("sat_addr_ack", int'(ack), 1);
    for (int i = 0; i < 5; i++) begin
      rd_byte(1'b1, d);
      chk($sformatf("sat_byte%0d", i), int'(d), int'(vecs[0].exp[i]));
    end
    i2c_start();
    chk("rs_xfer_cleared", int'(xfer_active), 0);
    wr_byte(8'h81, ack);
    chk("rs_addr_ack", int'(ack), 1);
    chk("rs_xfer", int'(xfer_active), 1);
    rd_byte(1'b0, d);
    chk("rs_byte0", int'(d), 8'hAA);
    i2c_stop();
    $display("txn: saturating read + repeated start");

    // Reset in the middle of read byte 1 while SDA is being pulled low
    tem_in = 14'h3F80; hum_in = 14'h0000;
    trigger();
    wait_conv();
    i2c_start();
    wr_byte(8'h81, ack);
    chk("rst_rd_ack", int'(ack), 1);
    rd_byte(1'b1, d);
    chk("rst_rd_byte0", int'(d), 8'hFE);
    for (int i = 0; i < 3; i++) clk_bit(1'b1, s);
    chk("rst_rd_bit_low", int'(s), 0);
    chk("pre_rst_driving", int'(bus.sda_oe), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_sda_oe", int'(bus.sda_oe), 0);
    chk("mid_rst_xfer", int'(xfer_active), 0);
    chk("mid_rst_busy", int'(conv_busy), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1; oe_seen = 0;
    for (int i = 0; i < 6; i++) clk_bit(1'b1, s);
    i2c_stop();
    mon_en = 1'b0;
    chk("post_rst_ignored", oe_seen, 0);
    i2c_start();
    wr_byte(8'h81, ack);
    chk("post_rst_ack", int'(ack), 1);
    for (int i = 0; i < 4; i++) begin
      rd_byte(i != 3, d);
      chk($sformatf("post_rst_byte%0d", i), int'(d), 0);
    end
    i2c_stop();
    $display("txn: reset mid-read, snapshot cleared");

    // Randomized reads against the reference model
    for (int it = 0; it < 10; it++) begin
      t = 14'($urandom); h = 14'($urandom);
      tem_in = t; hum_in = h;
      trigger();
      wait_conv();
      tem_in = 14'($urandom); hum_in = 14'($urandom);
      a7 = ($urandom_range(0, 2) == 0) ? 7'($urandom_range(0, 127)) : 7'h40;
      exp_ack = (a7 == 7'h40);
      i2c_start();
      wr_byte({a7, 1'b1}, ack);
      chk("rand_addr_ack", int'(ack), int'(exp_ack));
      n = 0;
      if (exp_ack) begin
        n = $urandom_range(1, 6);
        for (int i = 0; i < n; i++) begin
          rd_byte(i != n - 1, d);
          chk($sformatf("rand%0d_byte%0d", it, i), int'(d), int'(model_byte(i, t, h)));
        end
      end
      i2c_stop();
      $display("txn: random %0d addr=0x%02h tem=0x%04h hum=0x%04h bytes=%0d", it, {a7, 1'b1}, t, h, n);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/hygro_i2c_target.md
HYGRO_I2C_TARGET -- requirements
Module: hygro_i2c_target

Interface
REQ-001 SHALL have parameter ADDR, default 7'h40, the 7-bit target address.
REQ-002 SHALL have parameter CONV_CYCLES, default 16'd1000, the conversion duration in clk cycles (minimum 1).
REQ-003 SHALL have port clk, input, 1 bit: system clock, at least 16x the SCL frequency.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port scl_in, input, 1 bit: I2C SCL pin level, asynchronous to clk.
REQ-006 SHALL have port sda_in, input, 1 bit: I2C SDA pin level, asynchronous to clk.
REQ-007 SHALL have port sda_oe, output, 1 bit: 1 pulls SDA low; 0 releases SDA (open-drain, never drives high).
REQ-008 SHALL have port tem_in, input, 14 bits: live temperature sample.
REQ-009 SHALL have port hum_in, input, 14 bits: live humidity sample.
REQ-010 SHALL have port meas_req, output, 1 bit: one-clk pulse when a measurement trigger is accepted.
REQ-011 SHALL have port conv_busy, output, 1 bit: high while a conversion is in progress.
REQ-012 SHALL have port xfer_active, output, 1 bit: high from an address match until the next STOP or START.

Function
REQ-013 SHALL pass scl_in and sda_in through 2-FF synchronizers; all edges and conditions SHALL be detected on the synchronized levels.
REQ-014 SHALL detect START as an SDA fall while SCL is high, and STOP as an SDA rise while SCL is high.
REQ-015 SHALL implement states IDLE, ADDR, ADDR_ACK, WR, WR_ACK, RD, RD_ACK and IGNORE.
REQ-016 SHALL enter ADDR from any state on START, including a repeated START; the bit counter and byte index SHALL be cleared on entry.
REQ-017 SHALL enter IDLE from any state on STOP and release SDA in the same cycle.
REQ-018 SHALL sample SDA on each SCL rise in ADDR, WR and RD_ACK, MSB first; the 8th rise in ADDR completes {addr[6:0], rw}.
REQ-019 On a completed address byte: if the address matches and (rw=0, or rw=1 with conv_busy=0), SHALL go to ADDR_ACK; otherwise SHALL go to IGNORE, leaving SDA released (NACK).
REQ-020 SHALL pull SDA low from the first SCL fall after the 8th address or write-data bit until the next SCL fall.
REQ-021 After ADDR_ACK: rw=0 SHALL go to WR; rw=1 SHALL go to RD.
REQ-022 On the SCL fall that ends the write-address ACK, SHALL pulse meas_req for 1 clk, set conv_busy, and load the conversion counter with CONV_CYCLES.
REQ-023 A write address received while conv_busy=1 SHALL be ACKed but SHALL NOT restart the conversion or pulse meas_req.
REQ-024 In WR, data bytes SHALL be accepted, ACKed via WR_ACK, and discarded.
REQ-025 The conversion counter SHALL decrement each clk; on reaching 0 it SHALL snapshot {tem_in, hum_in} and clear conv_busy in the same cycle.
REQ-026 Read bytes SHALL be, in order: 0 = snap_tem[13:6]; 1 = {snap_tem[5:0], 2'b00}; 2 = snap_hum[13:6]; 3 = {snap_hum[5:0], 2'b00}; index 4 and above = 8'hFF.
REQ-027 The byte index SHALL saturate at 4.
REQ-028 In RD, each data bit SHALL be presented on the SCL fall (the first bit on the fall that ends ADDR_ACK) and held through SCL high; a 1 bit releases SDA, a 0 bit pulls it low.
REQ-029 In RD, SDA SHALL be released after the 8th bit; in RD_ACK the master ACK SHALL be sampled on the SCL rise.
REQ-030 In RD_ACK, ACK (SDA=0) SHALL go to RD with the next byte; NACK SHALL go to IGNORE.
REQ-031 In IGNORE, SDA SHALL stay released until START or STOP.
REQ-032 sda_oe SHALL change no later than 2 clk after the synchronized SCL edge that causes the change.

Reset
REQ-033 While rst=1, outputs SHALL be sda_oe=0, meas_req=0, conv_busy=0, xfer_active=0.
REQ-034 While rst=1, the state SHALL be IDLE, the snapshot SHALL be 0 and the counters SHALL be 0.
REQ-035 rst asserted mid-transfer or mid-conversion SHALL abort it; after release, the bus SHALL be ignored until the next START.

Verification
REQ-036 START, 0x80, STOP -> ACK on the 9th clock; meas_req pulses once; conv_busy=1 for CONV_CYCLES clk.
REQ-037 tem_in=14'h2ABC, hum_in=14'h1234, conversion done; START, 0x81, master ACK x3 then NACK -> bytes read 0xAA, 0xF0, 0x48, 0xD0; SDA released after the NACK.
REQ-038 START, 0x81 while conv_busy=1 -> SDA high on the 9th clock (NACK); no data bits driven until STOP.
REQ-039 START, 0x92 (wrong address) -> NACK; xfer_active=0; sda_oe=0 throughout.
REQ-040 Read with master ACK on 5 bytes -> byte 4 = 0xFF; repeated START then 0x81 restarts at byte 0.
REQ-041 rst pulsed during byte 1 of a read -> sda_oe=0 immediately; snapshot=0; the next read returns 0x00 0x00 0x00 0x00.
